// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package ifu_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 64;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

  // Fetch sequencing: request, wait for data, present to decode, or stopped.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_e;

endpackage : ifu_pkg

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch: request at PC, capture word, hold it for decode until commit.
// Latency: 3 cycles per instruction minimum (request, wait, present) with immediate ready/response.
// Backpressure: request held stable until imem_req_ready; instruction and PC held until inst_ready.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,

  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,

  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] snpc,

  input  logic              j,
  input  logic [ADDR_W-1:0] jPC,
  input  logic              halt,
  output logic              halted,
  output logic [ADDR_W-1:0] commit_cnt
);

  state_e              state_q,    state_d;
  logic [ADDR_W-1:0]   pc_q,       pc_d;
  logic [INST_W-1:0]   inst_q,     inst_d;
  logic [ADDR_W-1:0]   cnt_q,      cnt_d;
  logic                req_vld_q,  req_vld_d;
  logic                inst_vld_q, inst_vld_d;
  logic                halted_q,   halted_d;

  logic                commit;

  // The instruction is consumed only while it is actually being presented.
  assign commit = inst_vld_q & inst_ready;

  // Next-state, PC, captured word and commit counter; outputs derive from the next state so they come straight from flops.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (commit) begin
          // Redirect targets are forced to halfword alignment; PC update happens even when halting.
          pc_d    = j ? (jPC & ~64'h1) : (pc_q + 64'd4);
          cnt_d   = cnt_q + 64'd1;
          state_d = halt ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    req_vld_d  = (state_d == S_REQ);
    inst_vld_d = (state_d == S_VALID);
    halted_d   = (state_d == S_HALT);
  end

  // State register with synchronous active-low reset; reset lands in S_REQ so the first request is up immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      cnt_q      <= '0;
      req_vld_q  <= 1'b1;
      inst_vld_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      cnt_q      <= cnt_d;
      req_vld_q  <= req_vld_d;
      inst_vld_q <= inst_vld_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req_valid = req_vld_q;
  assign imem_addr      = pc_q;
  assign inst_valid     = inst_vld_q;
  assign inst           = inst_q;
  assign PC             = pc_q;
  assign snpc           = pc_q + 64'd4;
  assign halted         = halted_q;
  assign commit_cnt     = cnt_q;

endmodule : ifu_fetch

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: sequencing, redirect, stalls, halt, reset and PC wrap.
// Latency: checks the 3-cycle-per-instruction cadence.
// Backpressure: exercises imem_req_ready and inst_ready stalls.
module tb_ifu_fetch;
  import ifu_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [63:0]       imem_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [63:0]       PC;
  logic [63:0]       snpc;
  logic              j;
  logic [63:0]       jPC;
  logic              halt;
  logic              halted;
  logic [63:0]       commit_cnt;

  int total = 0;
  int bad   = 0;

  ifu_fetch #(.RESET_PC(64'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .PC             (PC),
    .snpc           (snpc),
    .j              (j),
    .jPC            (jPC),
    .halt           (halt),
    .halted         (halted),
    .commit_cnt     (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch starting in S_REQ with immediate ready/response and commit.
  task automatic fetch(input logic [63:0] exp_addr, input logic [31:0] word,
                       input logic jj, input logic [63:0] jtgt, input logic hh);
    chk("req_vld", {63'd0, imem_req_valid}, 64'd1);
    chk("req_addr", imem_addr, exp_addr);
    chk("ivld_in_req", {63'd0, inst_valid}, 64'd0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("req_vld_wait", {63'd0, imem_req_valid}, 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    step();
    imem_rsp_valid = 1'b0;
    chk("ivld", {63'd0, inst_valid}, 64'd1);
    chk("inst", {32'd0, inst}, {32'd0, word});
    chk("pc", PC, exp_addr);
    chk("no_req_in_valid", {63'd0, imem_req_valid}, 64'd0);
    inst_ready = 1'b1;
    j          = jj;
    jPC        = jtgt;
    halt       = hh;
    step();
    inst_ready = 1'b0;
    j          = 1'b0;
    jPC        = 64'd0;
    halt       = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    inst_ready     = 1'b0;
    j              = 1'b0;
    jPC            = 64'd0;
    halt           = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_pc", PC, 64'h8000_0000);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_cnt", commit_cnt, 64'd0);
    chk("rst_ivld", {63'd0, inst_valid}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_snpc", snpc, 64'h8000_0004);
    rst_n = 1'b1;

    // Three back-to-back fetches, 9 cycles, sequential addresses
    fetch(64'h8000_0000, 32'h0000_0013, 1'b0, 64'd0, 1'b0);
    fetch(64'h8000_0004, 32'h0010_0093, 1'b0, 64'd0, 1'b0);
    fetch(64'h8000_0008, 32'h0020_0113, 1'b0, 64'd0, 1'b0);
    chk("cnt_after_9", commit_cnt, 64'd3);

    // Redirect: odd target is aligned down
    fetch(64'h8000_000C, 32'h1000_006F, 1'b1, 64'h8000_0101, 1'b0);
    chk("jump_addr", imem_addr, 64'h8000_0100);
    chk("jump_snpc", snpc, 64'h8000_0104);
    chk("cnt_after_jump", commit_cnt, 64'd4);

    // Request stalled 4 cycles: valid and address must hold
    for (int i = 0; i < 4; i++) begin
      chk("stall_req_vld", {63'd0, imem_req_valid}, 64'd1);
      chk("stall_req_addr", imem_addr, 64'h8000_0100);
      step();
    end
    chk("stall_req_vld_end", {63'd0, imem_req_valid}, 64'd1);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    // One extra wait cycle with no response, then the word arrives
    chk("wait_no_req", {63'd0, imem_req_valid}, 64'd0);
    step();
    chk("wait_hold_no_req", {63'd0, imem_req_valid}, 64'd0);
    chk("wait_hold_no_ivld", {63'd0, inst_valid}, 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;

    // Decode stalls 5 cycles; a stray response must be ignored
    for (int i = 0; i < 5; i++) begin
      chk("dstall_ivld", {63'd0, inst_valid}, 64'd1);
      chk("dstall_inst", {32'd0, inst}, 64'h0000_0000_DEAD_BEEF);
      chk("dstall_pc", PC, 64'h8000_0100);
      chk("dstall_no_req", {63'd0, imem_req_valid}, 64'd0);
      imem_rsp_valid = (i == 1);
      imem_rsp_data  = 32'h1234_5678;
      step();
    end
    imem_rsp_valid = 1'b0;
    chk("stray_inst", {32'd0, inst}, 64'h0000_0000_DEAD_BEEF);
    chk("stray_cnt", commit_cnt, 64'd4);

    // Commit with halt: PC still advances, then nothing more
    inst_ready = 1'b1;
    halt       = 1'b1;
    step();
    halt = 1'b0;
    chk("halted", {63'd0, halted}, 64'd1);
    chk("halt_pc", PC, 64'h8000_0104);
    chk("halt_cnt", commit_cnt, 64'd5);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      imem_rsp_valid = i[0];
      chk("halt_no_req", {63'd0, imem_req_valid}, 64'd0);
      chk("halt_no_ivld", {63'd0, inst_valid}, 64'd0);
      step();
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    chk("halt_cnt_frozen", commit_cnt, 64'd5);
    chk("halt_sticky", {63'd0, halted}, 64'd1);

    // Reset out of halt, then reset again while waiting for a response
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst2_addr", imem_addr, 64'h8000_0000);
    chk("rst2_halted", {63'd0, halted}, 64'd0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("rst3_in_wait", {63'd0, imem_req_valid}, 64'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst3_req_vld", {63'd0, imem_req_valid}, 64'd1);
    chk("rst3_addr", imem_addr, 64'h8000_0000);
    chk("rst3_cnt", commit_cnt, 64'd0);
    chk("rst3_inst", {32'd0, inst}, 64'd0);

    // PC wraps modulo 2^64
    fetch(64'h8000_0000, 32'h0000_0067, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    chk("wrap_snpc", snpc, 64'd0);
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013, 1'b0, 64'd0, 1'b0);
    chk("wrap_pc", PC, 64'd0);
    chk("wrap_cnt", commit_cnt, 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ifu_fetch
